// File: rtl/arm_pipe_pkg.sv
// Shared pipeline tag types, forwarding-select encodings and the match rule
// used by the EX-stage forwarding/hazard logic.
package arm_pipe_pkg;

    localparam int unsigned ARM_REG_W = 4;

    localparam logic [1:0] FWD_SEL_ID  = 2'd0;
    localparam logic [1:0] FWD_SEL_MEM = 2'd1;
    localparam logic [1:0] FWD_SEL_WB  = 2'd2;

    localparam logic [ARM_REG_W-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic                 valid;
        logic [ARM_REG_W-1:0] dest;
        logic                 wb_en;
        logic                 mem_read;
    } pipe_tag_t;

    typedef struct packed {
        pipe_tag_t            tag;
        logic [ARM_REG_W-1:0] src1;
        logic                 src1_used;
        logic [ARM_REG_W-1:0] src2;
        logic                 src2_used;
    } ex_slot_t;

    // R15 reads come from the PC path, so a write to it is never forwarded.
    function automatic logic fwd_match(input logic                 valid,
                                       input logic                 wb_en,
                                       input logic [ARM_REG_W-1:0] dest,
                                       input logic [ARM_REG_W-1:0] src);
        return valid && wb_en && (dest == src) && (dest != PC_REG);
    endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One pipeline tag slot: synchronous reset, freeze hold, and load with optional bubble.
module fwd_tag_stage #(
    parameter type slot_t = arm_pipe_pkg::pipe_tag_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  freeze,
    input  logic  load,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    // A bubble clears every field, so an invalid slot never carries stale tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!freeze && load) begin
            q <= bubble ? slot_t'('0) : d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall, driven from the
// destination tags of instructions in flight through EX, MEM and WB.
module fwd_hazard_unit
    import arm_pipe_pkg::*;
#(
    parameter int unsigned REG_W = ARM_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_used,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src2_used,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             hazard_stall
);

    ex_slot_t  id_slot;
    ex_slot_t  ex_q;
    pipe_tag_t mem_q;
    pipe_tag_t wb_q;
    logic      ex_bubble;
    logic      unused_wb_bits;

    always_comb begin
        id_slot               = '0;
        id_slot.tag.valid     = 1'b1;
        id_slot.tag.dest      = id_dest;
        id_slot.tag.wb_en     = id_wb_en;
        id_slot.tag.mem_read  = id_mem_read;
        id_slot.src1          = id_src1;
        id_slot.src1_used     = id_src1_used;
        id_slot.src2          = id_src2;
        id_slot.src2_used     = id_src2_used;
    end

    // Flush and stall both turn the incoming EX slot into a bubble.
    assign ex_bubble = flush | hazard_stall;

    fwd_tag_stage #(.slot_t(ex_slot_t)) u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .load   (1'b1),
        .bubble (ex_bubble),
        .d      (id_slot),
        .q      (ex_q)
    );

    fwd_tag_stage #(.slot_t(pipe_tag_t)) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (ex_q.tag),
        .q      (mem_q)
    );

    fwd_tag_stage #(.slot_t(pipe_tag_t)) u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // MEM is checked first so the youngest producer wins.
    always_comb begin
        fwd_sel_a = FWD_SEL_ID;
        fwd_sel_b = FWD_SEL_ID;
        if (ex_q.tag.valid && ex_q.src1_used) begin
            if (fwd_match(mem_q.valid, mem_q.wb_en, mem_q.dest, ex_q.src1)) begin
                fwd_sel_a = FWD_SEL_MEM;
            end else if (fwd_match(wb_q.valid, wb_q.wb_en, wb_q.dest, ex_q.src1)) begin
                fwd_sel_a = FWD_SEL_WB;
            end
        end
        if (ex_q.tag.valid && ex_q.src2_used) begin
            if (fwd_match(mem_q.valid, mem_q.wb_en, mem_q.dest, ex_q.src2)) begin
                fwd_sel_b = FWD_SEL_MEM;
            end else if (fwd_match(wb_q.valid, wb_q.wb_en, wb_q.dest, ex_q.src2)) begin
                fwd_sel_b = FWD_SEL_WB;
            end
        end
    end

    always_comb begin
        hazard_stall = ex_q.tag.valid && ex_q.tag.wb_en && ex_q.tag.mem_read &&
                       ((id_src1_used && (id_src1 == ex_q.tag.dest)) ||
                        (id_src2_used && (id_src2 == ex_q.tag.dest)));
    end

    assign unused_wb_bits = wb_q.mem_read;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against an instruction-level
// model of the three in-flight instructions.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n, freeze, flush;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_src1_used, id_src2_used, id_wb_en, id_mem_read;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       hazard_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .flush        (flush),
        .id_src1      (id_src1),
        .id_src1_used (id_src1_used),
        .id_src2      (id_src2),
        .id_src2_used (id_src2_used),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_read  (id_mem_read),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .hazard_stall (hazard_stall)
    );

    typedef struct {
        bit v;
        int d;
        bit wb;
        bit ld;
        int s1;
        bit u1;
        int s2;
        bit u2;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;

    function automatic bit produces(input ins_t p, input int r);
        return p.v && p.wb && (p.d == r) && (r != 15);
    endfunction

    function automatic logic [1:0] exp_sel(input int s, input bit u);
        if (!(m_ex.v && u)) return 2'd0;
        if (produces(m_mem, s)) return 2'd1;
        if (produces(m_wb, s)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit exp_stall();
        if (!(m_ex.v && m_ex.wb && m_ex.ld)) return 1'b0;
        return (id_src1_used && int'(id_src1) == m_ex.d) ||
               (id_src2_used && int'(id_src2) == m_ex.d);
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compares outputs with the model, then advances both across one clock edge.
    task automatic tick(input string tag, input bit do_chk);
        bit   st;
        ins_t idi;
        #1;
        st = exp_stall();
        if (do_chk) begin
            chk({tag, ".sel_a"}, fwd_sel_a, exp_sel(m_ex.s1, m_ex.u1));
            chk({tag, ".sel_b"}, fwd_sel_b, exp_sel(m_ex.s2, m_ex.u2));
            chk({tag, ".stall"}, {1'b0, hazard_stall}, {1'b0, st});
        end
        idi = '{v: !(flush || st), d: int'(id_dest), wb: id_wb_en, ld: id_mem_read,
                s1: int'(id_src1), u1: id_src1_used, s2: int'(id_src2), u2: id_src2_used};
        @(posedge clk);
        if (!rst_n) begin
            m_ex.v  = 1'b0;
            m_mem.v = 1'b0;
            m_wb.v  = 1'b0;
        end else if (!freeze) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = idi;
        end
        #1;
    endtask

    task automatic set_id(input int s1, input bit u1, input int s2, input bit u2,
                          input int d, input bit wb, input bit ld);
        id_src1 = 4'(s1); id_src1_used = u1;
        id_src2 = 4'(s2); id_src2_used = u2;
        id_dest = 4'(d);  id_wb_en = wb; id_mem_read = ld;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_id();
        id_src1 = 4'($urandom_range(0, 15)); id_src1_used = 1'($urandom);
        id_src2 = 4'($urandom_range(0, 15)); id_src2_used = 1'($urandom);
        id_dest = 4'($urandom_range(0, 15)); id_wb_en = 1'($urandom);
        id_mem_read = 1'($urandom);
        #1;
    endtask

    function automatic int pick_reg();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
    endfunction

    initial begin
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;

        // reset with random ID traffic
        rand_id(); tick("rst0", 0);
        rand_id(); tick("rst1", 0);
        rst_n = 1'b1; rand_id();
        chk("post_rst.sel_a", fwd_sel_a, 2'd0);
        chk("post_rst.sel_b", fwd_sel_b, 2'd0);
        chk("post_rst.stall", {1'b0, hazard_stall}, 2'd0);
        tick("post_rst", 1);

        // ADD R1,R2,R3 ; SUB R2,R1,R3
        set_id(2, 1, 3, 1, 1, 1, 0); tick("add", 1);
        set_id(1, 1, 3, 1, 2, 1, 0); tick("sub", 1);
        nop();
        chk("sub_ex.sel_a", fwd_sel_a, 2'd1);
        chk("sub_ex.sel_b", fwd_sel_b, 2'd0);
        tick("sub_ex", 1);
        chk("sub_mem.sel_a", fwd_sel_a, 2'd0);
        tick("sub_mem", 1);

        // ADD R1 ; NOP ; ORR R4,R5,R1
        set_id(2, 1, 3, 1, 1, 1, 0); tick("add2", 1);
        nop();                       tick("nop2", 1);
        set_id(5, 1, 1, 1, 4, 1, 0); tick("orr", 1);
        nop();
        chk("orr_wb.sel_b", fwd_sel_b, 2'd2);
        tick("orr_wb", 1);

        // ADD R1 ; ADD R1 ; ORR R4,R5,R1 -> MEM producer wins
        set_id(2, 1, 3, 1, 1, 1, 0); tick("add3", 1);
        set_id(6, 1, 7, 1, 1, 1, 0); tick("add4", 1);
        set_id(5, 1, 1, 1, 4, 1, 0); tick("orr2", 1);
        nop();
        chk("orr_mem.sel_b", fwd_sel_b, 2'd1);
        tick("orr_mem", 1);
        tick("drain0", 1); tick("drain1", 1);

        // LDR R6,[R8] ; ADD R7,R6,R6
        set_id(8, 1, 0, 0, 6, 1, 1); tick("ldr", 1);
        set_id(6, 1, 6, 1, 7, 1, 0);
        chk("ldr_ex.stall", {1'b0, hazard_stall}, 2'd1);
        chk("ldr_ex.sel_a", fwd_sel_a, 2'd0);
        chk("ldr_ex.sel_b", fwd_sel_b, 2'd0);
        tick("ldr_ex", 1);
        chk("bubble.stall", {1'b0, hazard_stall}, 2'd0);
        tick("bubble", 1);
        nop();
        chk("ld_use.sel_a", fwd_sel_a, 2'd2);
        chk("ld_use.sel_b", fwd_sel_b, 2'd2);
        tick("ld_use", 1);

        // R15 producer then R15 consumer
        set_id(2, 1, 3, 1, 15, 1, 0); tick("pc_wr", 1);
        set_id(15, 1, 15, 1, 4, 1, 0); tick("pc_rd", 1);
        nop();
        chk("pc_rd.sel_a", fwd_sel_a, 2'd0);
        chk("pc_rd.sel_b", fwd_sel_b, 2'd0);
        tick("pc_rd_ex", 1);

        // flush together with a load-use stall
        set_id(8, 1, 0, 0, 6, 1, 1); tick("ldr2", 1);
        set_id(6, 1, 6, 1, 7, 1, 0); flush = 1'b1; #1;
        chk("flush.stall", {1'b0, hazard_stall}, 2'd1);
        tick("flush", 1);
        flush = 1'b0;
        set_id(7, 1, 7, 1, 9, 1, 0); tick("after_flush", 1);
        nop();
        chk("flushed.sel_a", fwd_sel_a, 2'd0);
        chk("flushed.sel_b", fwd_sel_b, 2'd0);
        tick("flushed", 1);

        // freeze for three cycles mid-forward
        set_id(2, 1, 3, 1, 1, 1, 0); tick("add5", 1);
        set_id(1, 1, 1, 1, 2, 1, 0); tick("sub5", 1);
        freeze = 1'b1; nop();
        for (int i = 0; i < 3; i++) begin
            chk("freeze.sel_a", fwd_sel_a, 2'd1);
            chk("freeze.sel_b", fwd_sel_b, 2'd1);
            tick("freeze", 1);
        end
        freeze = 1'b0;
        chk("unfreeze.sel_a", fwd_sel_a, 2'd1);
        tick("unfreeze", 1);
        chk("resumed.sel_a", fwd_sel_a, 2'd0);

        // reset while a forward is active
        set_id(2, 1, 3, 1, 1, 1, 0); tick("add6", 1);
        set_id(1, 1, 1, 1, 2, 1, 0); tick("sub6", 1);
        chk("pre_rst.sel_a", fwd_sel_a, 2'd1);
        rst_n = 1'b0; tick("mid_rst", 1);
        rst_n = 1'b1; nop();
        chk("mid_rst.sel_a", fwd_sel_a, 2'd0);
        chk("mid_rst.sel_b", fwd_sel_b, 2'd0);
        tick("mid_rst_rel", 1);

        // random traffic over a small register set to provoke frequent matches
        for (int i = 0; i < 600; i++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            freeze = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            set_id(pick_reg(), 1'($urandom), pick_reg(), 1'($urandom),
                   pick_reg(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            tick("rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
